// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter for a small bank of config registers; one access per IDLE->GRANT->RESP pass.
// Grant is issued 1 cycle after the request is seen and ack 2 cycles after; ena low freezes everything, holding gnt/ack.
module reg_bank_arbiter #(
    parameter int NUM_REGS   = 2,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic                          req_a,
    input  logic                          req_b,
    input  logic                          we_a,
    input  logic                          we_b,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    input  logic [REG_WIDTH-1:0]          wdata_a,
    input  logic [REG_WIDTH-1:0]          wdata_b,
    output logic                          gnt_a,
    output logic                          gnt_b,
    output logic                          ack_a,
    output logic                          ack_b,
    output logic                          err_a,
    output logic                          err_b,
    output logic [REG_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*REG_WIDTH-1:0] config_regs
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t                        state_q, state_d;
    logic                          win_b_q, win_b_d;
    logic                          last_b_q, last_b_d;
    logic                          we_q, we_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [REG_WIDTH-1:0]          wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]          rdata_q, rdata_d;
    logic                          err_q, err_d;
    logic [NUM_REGS*REG_WIDTH-1:0] regs_q, regs_d;

    logic                          pick_b;
    logic                          hit;
    logic [REG_WIDTH-1:0]          rd_val;

    // B wins only if A is absent, or on a tie when A won last time.
    assign pick_b = req_b & (~req_a | ~last_b_q);

    always_comb begin
        hit    = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) begin
                hit    = 1'b1;
                rd_val = regs_q[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_b_d  = win_b_q;
        last_b_d = last_b_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        regs_d   = regs_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        win_b_d  = pick_b;
                        last_b_d = pick_b;
                        we_d     = pick_b ? we_b    : we_a;
                        addr_d   = pick_b ? addr_b  : addr_a;
                        wdata_d  = pick_b ? wdata_b : wdata_a;
                        state_d  = GRANT;
                    end
                end
                GRANT: begin
                    err_d   = ~hit;
                    rdata_d = (hit && !we_q) ? rd_val : '0;
                    if (we_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == ADDR_WIDTH'(i)) begin
                                regs_d[i*REG_WIDTH +: REG_WIDTH] = wdata_q;
                            end
                        end
                    end
                    state_d = RESP;
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            win_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            regs_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

    assign gnt_a       = (state_q == GRANT) & ~win_b_q;
    assign gnt_b       = (state_q == GRANT) &  win_b_q;
    assign ack_a       = (state_q == RESP)  & ~win_b_q;
    assign ack_b       = (state_q == RESP)  &  win_b_q;
    assign err_a       = ack_a & err_q;
    assign err_b       = ack_b & err_q;
    assign rdata       = (state_q == RESP) ? rdata_q : '0;
    assign config_regs = regs_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: scoreboard of expected acks, exact-cycle grant/ack checks.
module tb_reg_bank_arbiter;

    localparam int NR = 2;
    localparam int RW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rstb, ena;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [RW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, ack_a, ack_b, err_a, err_b;
    logic [RW-1:0] rdata;
    logic [NR*RW-1:0] config_regs;

    reg_bank_arbiter #(.NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
        .err_a(err_a), .err_b(err_b), .rdata(rdata), .config_regs(config_regs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          port_b;
        logic [RW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sbq[$];
    logic [RW-1:0] mdl [NR];
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [NR*RW-1:0] mdl_flat();
        return {mdl[1], mdl[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ack(string tag, bit pb);
        exp_t e;
        chk({tag, "_ack_a"}, 32'(ack_a), 32'(!pb));
        chk({tag, "_ack_b"}, 32'(ack_b), 32'(pb));
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb_empty observed=ack expected=queued_entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_port"},  32'(ack_b), 32'(e.port_b));
            chk({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
            chk({tag, "_err"},   32'(pb ? err_b : err_a), 32'(e.err));
            chk({tag, "_err_other"}, 32'(pb ? err_a : err_b), 32'd0);
        end
    endtask

    // One access from a single port; starts in an IDLE cycle, ends in the next IDLE cycle.
    task automatic single(string tag, bit pb, bit we, logic [AW-1:0] addr, logic [RW-1:0] wd);
        exp_t           e;
        bit             inr;
        logic [NR*RW-1:0] old_flat;
        inr      = (addr < AW'(NR));
        old_flat = mdl_flat();
        e.port_b = pb;
        e.err    = !inr;
        e.rdata  = (inr && !we) ? mdl[addr[0]] : '0;
        if (inr && we) mdl[addr[0]] = wd;
        sbq.push_back(e);
        if (pb) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
        else    begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
        chk({tag, "_gnt_early"}, 32'(gnt_a | gnt_b), 32'd0);
        tick();
        chk({tag, "_gnt_a"}, 32'(gnt_a), 32'(!pb));
        chk({tag, "_gnt_b"}, 32'(gnt_b), 32'(pb));
        chk({tag, "_cfg_grant"}, 32'(config_regs), 32'(old_flat));
        // Scramble fields after capture: the access must not change.
        if (pb) begin req_b = 0; we_b = ~we; addr_b = ~addr; wdata_b = ~wd; end
        else    begin req_a = 0; we_a = ~we; addr_a = ~addr; wdata_a = ~wd; end
        tick();
        check_ack(tag, pb);
        chk({tag, "_cfg"}, 32'(config_regs), 32'(mdl_flat()));
        tick();
        chk({tag, "_ack_done"}, 32'(ack_a | ack_b), 32'd0);
    endtask

    // Both ports request continuously; winners must alternate starting with first_b.
    task automatic contend(string tag, int n, bit first_b);
        for (int k = 0; k < n; k++) begin
            exp_t          e;
            bit            pb;
            logic [RW-1:0] wa, wb;
            pb = first_b ^ k[0];
            wa = 8'h10 + 8'(k);
            wb = 8'h20 + 8'(k);
            req_a = 1; we_a = 1; addr_a = 0; wdata_a = wa;
            req_b = 1; we_b = 1; addr_b = 1; wdata_b = wb;
            e.port_b = pb;
            e.rdata  = '0;
            e.err    = 1'b0;
            sbq.push_back(e);
            if (pb) mdl[1] = wb; else mdl[0] = wa;
            tick();
            chk({tag, "_gnt_a"}, 32'(gnt_a), 32'(!pb));
            chk({tag, "_gnt_b"}, 32'(gnt_b), 32'(pb));
            tick();
            check_ack(tag, pb);
            chk({tag, "_cfg"}, 32'(config_regs), 32'(mdl_flat()));
            if (k == n - 1) begin req_a = 0; req_b = 0; end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gcnt;
        rstb = 0; ena = 1;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        mdl[0] = '0; mdl[1] = '0;
        tick();
        tick();
        chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
        chk("rst_ack", 32'({ack_a, ack_b}), 32'd0);
        chk("rst_err", 32'({err_a, err_b}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cfg", 32'(config_regs), 32'd0);
        rstb = 1;
        tick();

        single("wr_a5", 0, 1, 2'd1, 8'hA5);
        single("rd_b", 1, 0, 2'd1, 8'h00);
        contend("tie1", 4, 0);
        single("oor_wr", 0, 1, 2'd3, 8'hFF);
        single("oor_rd", 1, 0, 2'd2, 8'h00);
        single("rd_a0", 0, 0, 2'd0, 8'h00);

        // ena low for 5 cycles while granted.
        sbq.push_back('{port_b: 1'b0, rdata: 8'h00, err: 1'b0});
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'h5A;
        tick();
        chk("ena_gnt_first", 32'(gnt_a), 32'd1);
        ena = 0; req_a = 0; wdata_a = 8'h00;
        gcnt = gnt_a ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gnt_a) gcnt++;
            chk("ena_cfg_hold", 32'(config_regs), 32'(mdl_flat()));
            chk("ena_no_ack", 32'(ack_a | ack_b), 32'd0);
        end
        tick();
        if (gnt_a) gcnt++;
        ena = 1;
        mdl[0] = 8'h5A;
        tick();
        chk("ena_gnt_cycles", 32'(gcnt), 32'd6);
        check_ack("ena", 0);
        chk("ena_cfg", 32'(config_regs), 32'(mdl_flat()));
        tick();
        chk("ena_one_ack", 32'(ack_a | ack_b | gnt_a | gnt_b), 32'd0);

        // Reset asserted during GRANT of a 0x3C write.
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'h3C;
        tick();
        chk("rstg_gnt", 32'(gnt_a), 32'd1);
        rstb = 0; req_a = 0;
        #1;
        chk("rstg_gnt_cleared", 32'(gnt_a | gnt_b), 32'd0);
        chk("rstg_cfg", 32'(config_regs), 32'd0);
        mdl[0] = '0; mdl[1] = '0;
        tick();
        tick();
        rstb = 1;
        tick();
        chk("rstg_no_ack", 32'({ack_a, ack_b, gnt_a, gnt_b}), 32'd0);
        chk("rstg_cfg_after", 32'(config_regs), 32'd0);
        contend("tie2", 2, 0);

        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
